// File: rtl/ov5640_cfg_sequencer.sv
// OV5640 register-table sequencer.
// Walks the register ROM from index 0. Each non-terminator entry becomes one
// SCCB/I2C write to the I2C master. The sequencer waits out the sensor power-up
// delay, spaces writes with an idle gap, retries NACKed writes, and stops on the
// 8'hff terminator entry.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   restart           one-cycle pulse; re-runs the table (honoured in DONE/ERROR only)
//   lut_index         ROM address
//   lut_data          ROM word {dev_addr[31:24], reg_addr[23:8], reg_data[7:0]}
//   i2c_req           write request, held until i2c_done is sampled
//   i2c_dev_addr      device write address, stable while i2c_req is high
//   i2c_reg_addr      register address, stable while i2c_req is high
//   i2c_reg_data      register data, stable while i2c_req is high
//   i2c_done          transfer-complete pulse from the I2C master
//   i2c_nack          NACK flag, valid with i2c_done
//   cfg_done          table finished on terminator (held)
//   cfg_error         retry exhaustion, unpopulated word or table overrun (held)
//   cfg_count         number of entries written successfully (saturating)
module ov5640_cfg_sequencer #(
    parameter logic [23:0] POWERUP_CYCLES = 24'd1_000_000,
    parameter logic [15:0] GAP_CYCLES     = 16'd500,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [9:0]  LAST_INDEX     = 10'd1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    output logic [9:0]  lut_index,
    input  logic [31:0] lut_data,
    output logic        i2c_req,
    output logic [7:0]  i2c_dev_addr,
    output logic [15:0] i2c_reg_addr,
    output logic [7:0]  i2c_reg_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [9:0]  cfg_count
);

    localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned DLY_W   = 24;
    localparam int unsigned CMP_W   = DLY_W + 1;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state;
    logic [DLY_W-1:0]   dly_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_pend;   // gap ends in a re-issue rather than a fetch

    // Delay terminal counts, widened so that a zero parameter still exits after one clock
    logic pwrup_last_c;
    logic gap_last_c;

    always_comb begin
        pwrup_last_c = (CMP_W'(dly_cnt) + CMP_W'(1)) >= CMP_W'(POWERUP_CYCLES);
        gap_last_c   = (CMP_W'(dly_cnt) + CMP_W'(1)) >= CMP_W'(GAP_CYCLES);
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_PWRUP;
            dly_cnt      <= '0;
            retry_cnt    <= '0;
            retry_pend   <= 1'b0;
            lut_index    <= '0;
            i2c_req      <= 1'b0;
            i2c_dev_addr <= '0;
            i2c_reg_addr <= '0;
            i2c_reg_data <= '0;
            cfg_done     <= 1'b0;
            cfg_error    <= 1'b0;
            cfg_count    <= '0;
        end else begin
            case (state)
                S_PWRUP: begin
                    if (pwrup_last_c) begin
                        dly_cnt <= '0;
                        state   <= S_FETCH;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end

                // lut_index is already driven; give the ROM one clock
                S_FETCH: state <= S_LATCH;

                S_LATCH: begin
                    i2c_dev_addr <= lut_data[31:24];
                    i2c_reg_addr <= lut_data[23:8];
                    i2c_reg_data <= lut_data[7:0];
                    if (lut_data[31:24] == 8'hff) begin
                        cfg_done <= 1'b1;
                        state    <= S_DONE;
                    end else if (lut_data[31:24] == 8'h00) begin
                        cfg_error <= 1'b1;
                        state     <= S_ERROR;
                    end else begin
                        i2c_req <= 1'b1;
                        state   <= S_ISSUE;
                    end
                end

                // Request is raised on entry; the master needs at least a clock to respond
                S_ISSUE: state <= S_WAIT;

                S_WAIT: begin
                    if (i2c_done) begin
                        i2c_req <= 1'b0;
                        dly_cnt <= '0;
                        if (!i2c_nack) begin
                            retry_cnt  <= '0;
                            retry_pend <= 1'b0;
                            if (cfg_count != 10'h3ff) begin
                                cfg_count <= cfg_count + 10'd1;
                            end
                            if (lut_index == LAST_INDEX) begin
                                cfg_error <= 1'b1;
                                state     <= S_ERROR;
                            end else begin
                                lut_index <= lut_index + 10'd1;
                                state     <= S_GAP;
                            end
                        end else if (32'(retry_cnt) < MAX_RETRY) begin
                            retry_cnt  <= retry_cnt + RETRY_W'(1);
                            retry_pend <= 1'b1;
                            state      <= S_GAP;
                        end else begin
                            cfg_error <= 1'b1;
                            state     <= S_ERROR;
                        end
                    end
                end

                S_GAP: begin
                    if (gap_last_c) begin
                        dly_cnt <= '0;
                        if (retry_pend) begin
                            i2c_req <= 1'b1;
                            state   <= S_ISSUE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end

                S_DONE, S_ERROR: begin
                    if (restart) begin
                        cfg_done   <= 1'b0;
                        cfg_error  <= 1'b0;
                        cfg_count  <= '0;
                        lut_index  <= '0;
                        retry_cnt  <= '0;
                        retry_pend <= 1'b0;
                        dly_cnt    <= '0;
                        state      <= S_PWRUP;
                    end
                end

                default: state <= S_ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_ov5640_cfg_sequencer.sv
// Self-checking bench for ov5640_cfg_sequencer: ROM array, behavioural I2C
// slave with per-entry NACK plan, and a table-walk reference model.
module tb_ov5640_cfg_sequencer;

    localparam int unsigned PWR  = 16;
    localparam int unsigned GAPC = 4;
    localparam int unsigned MAXR = 3;
    localparam int          LAST = 1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic [9:0]  lut_index;
    logic [31:0] lut_data;
    logic        i2c_req;
    logic [7:0]  i2c_dev_addr;
    logic [15:0] i2c_reg_addr;
    logic [7:0]  i2c_reg_data;
    logic        i2c_done = 1'b0;
    logic        i2c_nack = 1'b0;
    logic        cfg_done;
    logic        cfg_error;
    logic [9:0]  cfg_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] rom [0:1023];
    int          nack_plan [0:1023];
    int          nack_left [0:1023];
    int          dmin = 10;
    int          dmax = 10;

    logic [31:0] txq [$];
    logic [31:0] exp_q [$];
    bit          exp_done;
    bit          exp_err;
    int          exp_count;
    int          exp_idx;

    ov5640_cfg_sequencer #(
        .POWERUP_CYCLES(24'(PWR)),
        .GAP_CYCLES    (16'(GAPC)),
        .MAX_RETRY     (MAXR),
        .LAST_INDEX    (10'(LAST))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .restart     (restart),
        .lut_index   (lut_index),
        .lut_data    (lut_data),
        .i2c_req     (i2c_req),
        .i2c_dev_addr(i2c_dev_addr),
        .i2c_reg_addr(i2c_reg_addr),
        .i2c_reg_data(i2c_reg_data),
        .i2c_done    (i2c_done),
        .i2c_nack    (i2c_nack),
        .cfg_done    (cfg_done),
        .cfg_error   (cfg_error),
        .cfg_count   (cfg_count)
    );

    always #5 clk = ~clk;

    assign lut_data = rom[lut_index];

    // I2C slave: records each request, checks bus stability, answers after a delay
    always begin : i2c_slave
        logic [31:0] w;
        int          d;
        @(negedge clk);
        if (rst_n && i2c_req) begin
            w = {i2c_dev_addr, i2c_reg_addr, i2c_reg_data};
            txq.push_back(w);
            d = int'($urandom_range(dmax, dmin));
            for (int i = 0; i < d && rst_n; i++) begin
                @(negedge clk);
                if (rst_n && i2c_req) begin
                    checks++;
                    if ({i2c_dev_addr, i2c_reg_addr, i2c_reg_data} !== w) begin
                        errors++;
                        $display("FAIL bus_stable got %h exp %h", {i2c_dev_addr, i2c_reg_addr, i2c_reg_data}, w);
                    end
                end
            end
            if (rst_n) begin
                i2c_nack = (nack_left[lut_index] > 0);
                if (nack_left[lut_index] > 0) nack_left[lut_index]--;
                i2c_done = 1'b1;
                @(negedge clk);
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
                if (rst_n) begin
                    checks++;
                    if (i2c_req !== 1'b0) begin
                        errors++;
                        $display("FAIL req_drop got %b exp 0", i2c_req);
                    end
                end
            end
        end
    end

    // Reference: walk the table by the rules, entry by entry
    function automatic void ref_model();
        int  idx;
        int  cnt;
        int  tries;
        bit  fin;
        logic [7:0] dv;
        idx = 0; cnt = 0; fin = 1'b0;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        while (!fin) begin
            dv = rom[idx][31:24];
            if (dv == 8'hff) begin
                exp_done = 1'b1; fin = 1'b1;
            end else if (dv == 8'h00) begin
                exp_err = 1'b1; fin = 1'b1;
            end else begin
                tries = (nack_plan[idx] > int'(MAXR)) ? int'(MAXR) + 1 : nack_plan[idx] + 1;
                for (int t = 0; t < tries; t++) exp_q.push_back(rom[idx]);
                if (nack_plan[idx] > int'(MAXR)) begin
                    exp_err = 1'b1; fin = 1'b1;
                end else begin
                    if (cnt < 1023) cnt++;
                    if (idx == LAST) begin
                        exp_err = 1'b1; fin = 1'b1;
                    end else begin
                        idx++;
                    end
                end
            end
        end
        exp_count = cnt;
        exp_idx   = idx;
    endfunction

    function automatic int q_diff();
        int n;
        n = (txq.size() < exp_q.size()) ? txq.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (txq[i] !== exp_q[i]) return i;
        if (txq.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic clear_tables();
        for (int i = 0; i < 1024; i++) begin
            rom[i] = 32'h0;
            nack_plan[i] = 0;
        end
    endtask

    task automatic load_spec_rom();
        clear_tables();
        rom[0] = 32'h78_3008_02;
        rom[1] = 32'h78_3103_02;
        rom[2] = 32'h78_3017_ff;
        rom[3] = 32'hff_ffff_ff;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        restart = 1'b0;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        repeat (2) @(negedge clk);
        txq.delete();
        for (int i = 0; i < 1024; i++) nack_left[i] = nack_plan[i];
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_end(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cfg_done || cfg_error) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({lut_index, i2c_req, i2c_dev_addr, i2c_reg_addr, i2c_reg_data, cfg_done, cfg_error, cfg_count} !== '0) begin
            errors++;
            $display("FAIL reset_values idx=%h req=%b dev=%h ra=%h rd=%h done=%b err=%b cnt=%h exp all 0",
                     lut_index, i2c_req, i2c_dev_addr, i2c_reg_addr, i2c_reg_data, cfg_done, cfg_error, cfg_count);
        end
    endtask

    task automatic test_normal();
        bit to;
        int d;
        load_spec_rom();
        dmin = 10; dmax = 10;
        ref_model();
        hold_reset();
        release_reset();
        for (int k = 1; k <= PWR + 2; k++) begin
            @(posedge clk); #1;
            if (k == PWR + 1) begin
                checks++;
                if (i2c_req !== 1'b0) begin errors++; $display("FAIL normal_req_early got %b exp 0", i2c_req); end
            end
            if (k == PWR + 2) begin
                checks++;
                if (i2c_req !== 1'b1 || i2c_reg_addr !== 16'h3008 || i2c_reg_data !== 8'h02) begin
                    errors++;
                    $display("FAIL normal_first_req got req=%b ra=%h rd=%h exp 1 3008 02", i2c_req, i2c_reg_addr, i2c_reg_data);
                end
            end
        end
        wait_end(5000, to);
        checks++;
        if (to) begin errors++; $display("FAIL normal_timeout got no end exp done"); end
        d = q_diff();
        checks++;
        if (d != -1) begin errors++; $display("FAIL normal_txlist diff_at=%0d got_n=%0d exp_n=%0d", d, txq.size(), exp_q.size()); end
        checks++;
        if (cfg_done !== 1'b1 || cfg_error !== 1'b0 || cfg_count !== 10'd3 || lut_index !== 10'd3) begin
            errors++;
            $display("FAIL normal_final got done=%b err=%b cnt=%0d idx=%0d exp 1 0 3 3", cfg_done, cfg_error, cfg_count, lut_index);
        end
    endtask

    task automatic test_nack_retry();
        bit to;
        int n3103;
        load_spec_rom();
        nack_plan[1] = 2;
        dmin = 10; dmax = 10;
        ref_model();
        hold_reset();
        release_reset();
        wait_end(5000, to);
        checks++;
        if (to || q_diff() != -1) begin errors++; $display("FAIL retry_txlist timeout=%b got_n=%0d exp_n=%0d", to, txq.size(), exp_q.size()); end
        n3103 = 0;
        foreach (txq[i]) if (txq[i] === 32'h78_3103_02) n3103++;
        checks++;
        if (n3103 != 3) begin errors++; $display("FAIL retry_entry1_issues got %0d exp 3", n3103); end
        checks++;
        if (cfg_done !== 1'b1 || cfg_error !== 1'b0 || cfg_count !== 10'd3) begin
            errors++;
            $display("FAIL retry_final got done=%b err=%b cnt=%0d exp 1 0 3", cfg_done, cfg_error, cfg_count);
        end
    endtask

    task automatic test_retry_exhaustion();
        bit to;
        int n3008;
        load_spec_rom();
        nack_plan[0] = 100;
        dmin = 10; dmax = 10;
        ref_model();
        hold_reset();
        release_reset();
        wait_end(5000, to);
        repeat (30) begin
            @(negedge clk);
            checks++;
            if (i2c_req !== 1'b0) begin errors++; $display("FAIL exhaust_req_idle got %b exp 0", i2c_req); end
        end
        n3008 = 0;
        foreach (txq[i]) if (txq[i][23:8] === 16'h3008) n3008++;
        checks++;
        if (to || txq.size() != 4 || n3008 != 4 || q_diff() != -1) begin
            errors++;
            $display("FAIL exhaust_requests timeout=%b got_n=%0d n3008=%0d exp 4", to, txq.size(), n3008);
        end
        checks++;
        if (cfg_error !== 1'b1 || cfg_done !== 1'b0 || lut_index !== 10'd0 || cfg_count !== 10'd0) begin
            errors++;
            $display("FAIL exhaust_final got err=%b done=%b idx=%0d cnt=%0d exp 1 0 0 0", cfg_error, cfg_done, lut_index, cfg_count);
        end
    endtask

    task automatic test_unpopulated();
        bit to;
        clear_tables();
        rom[0] = 32'h78_3008_02;
        rom[1] = 32'h78_3103_02;
        dmin = 10; dmax = 10;
        ref_model();
        hold_reset();
        release_reset();
        wait_end(5000, to);
        checks++;
        if (to || txq.size() != 2 || q_diff() != -1) begin
            errors++;
            $display("FAIL unpop_requests timeout=%b got_n=%0d exp_n=2", to, txq.size());
        end
        checks++;
        if (cfg_error !== 1'b1 || cfg_done !== 1'b0 || lut_index !== 10'd2 || cfg_count !== 10'd2) begin
            errors++;
            $display("FAIL unpop_final got err=%b done=%b idx=%0d cnt=%0d exp 1 0 2 2", cfg_error, cfg_done, lut_index, cfg_count);
        end
    endtask

    task automatic test_random();
        bit to;
        int n;
        int d;
        for (int it = 0; it < 5; it++) begin
            clear_tables();
            n = int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++) begin
                rom[i] = {8'($urandom_range(254, 1)), 16'($urandom), 8'($urandom)};
                nack_plan[i] = ($urandom_range(7, 0) == 0) ? 4 : int'($urandom_range(2, 0));
            end
            rom[n] = ($urandom_range(1, 0) == 1) ? {8'hff, 24'($urandom)} : 32'h0;
            dmin = 1; dmax = 50;
            ref_model();
            hold_reset();
            release_reset();
            wait_end(8000, to);
            d = q_diff();
            checks++;
            if (to || d != -1) begin
                errors++;
                $display("FAIL random%0d_txlist timeout=%b diff_at=%0d got_n=%0d exp_n=%0d", it, to, d, txq.size(), exp_q.size());
            end
            checks++;
            if (cfg_done !== exp_done || cfg_error !== exp_err || int'(cfg_count) != exp_count || int'(lut_index) != exp_idx) begin
                errors++;
                $display("FAIL random%0d_final got done=%b err=%b cnt=%0d idx=%0d exp %b %b %0d %0d",
                         it, cfg_done, cfg_error, cfg_count, lut_index, exp_done, exp_err, exp_count, exp_idx);
            end
        end
    endtask

    task automatic test_restart();
        bit to;
        bit seen;
        load_spec_rom();
        dmin = 1; dmax = 50;
        ref_model();
        hold_reset();
        release_reset();
        wait_end(5000, to);
        checks++;
        if (to || cfg_done !== 1'b1) begin errors++; $display("FAIL restart_first_run timeout=%b done=%b exp 1", to, cfg_done); end
        txq.delete();
        for (int i = 0; i < 1024; i++) nack_left[i] = nack_plan[i];
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
        checks++;
        if (cfg_done !== 1'b0 || cfg_count !== 10'd0 || lut_index !== 10'd0) begin
            errors++;
            $display("FAIL restart_clear got done=%b cnt=%0d idx=%0d exp 0 0 0", cfg_done, cfg_count, lut_index);
        end
        for (int k = 1; k <= PWR + 2; k++) begin
            @(posedge clk); #1;
            if (k == 5) i2c_done = 1'b1;       // stray completion during power-up
            if (k == 6) i2c_done = 1'b0;
            if (k == PWR + 1) begin
                checks++;
                if (i2c_req !== 1'b0) begin errors++; $display("FAIL restart_req_early got %b exp 0", i2c_req); end
            end
            if (k == PWR + 2) begin
                checks++;
                if (i2c_req !== 1'b1 || i2c_reg_addr !== 16'h3008 || i2c_reg_data !== 8'h02) begin
                    errors++;
                    $display("FAIL restart_reissue got req=%b ra=%h rd=%h exp 1 3008 02", i2c_req, i2c_reg_addr, i2c_reg_data);
                end
            end
        end
        // restart while a transfer is pending must be ignored
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (i2c_req === 1'b1 && cfg_count === 10'd1) seen = 1'b1;
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        wait_end(5000, to);
        checks++;
        if (!seen || to || q_diff() != -1 || cfg_done !== 1'b1 || cfg_count !== 10'd3 || lut_index !== 10'd3) begin
            errors++;
            $display("FAIL restart_midrun seen=%b timeout=%b got_n=%0d done=%b cnt=%0d idx=%0d exp 3 1 3 3",
                     seen, to, txq.size(), cfg_done, cfg_count, lut_index);
        end
    endtask

    task automatic test_async_reset();
        bit to;
        bit seen;
        load_spec_rom();
        dmin = 10; dmax = 10;
        ref_model();
        hold_reset();
        release_reset();
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk);
            if (i2c_req === 1'b1 && cfg_count === 10'd1) seen = 1'b1;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!seen || i2c_req !== 1'b0) begin errors++; $display("FAIL areset_req seen=%b got %b exp 0", seen, i2c_req); end
        checks++;
        if ({lut_index, i2c_dev_addr, i2c_reg_addr, i2c_reg_data, cfg_done, cfg_error, cfg_count} !== '0) begin
            errors++;
            $display("FAIL areset_outputs idx=%h dev=%h ra=%h rd=%h done=%b err=%b cnt=%h exp all 0",
                     lut_index, i2c_dev_addr, i2c_reg_addr, i2c_reg_data, cfg_done, cfg_error, cfg_count);
        end
        repeat (2) @(negedge clk);
        txq.delete();
        for (int i = 0; i < 1024; i++) nack_left[i] = nack_plan[i];
        release_reset();
        wait_end(5000, to);
        checks++;
        if (to || q_diff() != -1 || cfg_done !== 1'b1 || cfg_count !== 10'd3) begin
            errors++;
            $display("FAIL areset_replay timeout=%b got_n=%0d exp_n=%0d done=%b cnt=%0d", to, txq.size(), exp_q.size(), cfg_done, cfg_count);
        end
    endtask

    initial begin
        clear_tables();
        for (int i = 0; i < 1024; i++) nack_left[i] = 0;
        test_reset();
        test_normal();
        test_nack_retry();
        test_retry_exhaustion();
        test_unpopulated();
        test_random();
        test_restart();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
